// File: rtl/execute_pipe_pkg.sv
// rtl/execute_pipe_pkg.sv - shared icode, ALU function, status and register constants for the execute stage
package execute_pipe_pkg;

  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] AOK = 4'h1;
  localparam logic [3:0] HLT = 4'h2;
  localparam logic [3:0] ADR = 4'h3;
  localparam logic [3:0] INS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/execute_pipe_alu.sv
// rtl/execute_pipe_alu.sv - combinational ALU producing the result and the ZF/SF/OF flags
module alu_core
  import execute_pipe_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [3:0]        alu_fn,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] result,
  output logic              zf,
  output logic              sf,
  output logic              of
);

  logic sign_a;
  logic sign_b;
  logic sign_r;

  always_comb begin
    sign_a = alu_a[DATA_W-1];
    sign_b = alu_b[DATA_W-1];
    case (alu_fn)
      ALU_SUB: result = alu_b - alu_a;
      ALU_AND: result = alu_b & alu_a;
      ALU_XOR: result = alu_b ^ alu_a;
      default: result = alu_b + alu_a;
    endcase
    sign_r = result[DATA_W-1];
    // Subtraction overflows relative to B because the result is B - A.
    case (alu_fn)
      ALU_SUB: of = (sign_a != sign_b) && (sign_r != sign_b);
      ALU_AND: of = 1'b0;
      ALU_XOR: of = 1'b0;
      default: of = (sign_a == sign_b) && (sign_r != sign_a);
    endcase
    zf = (result == '0);
    sf = sign_r;
  end

endmodule

// File: rtl/execute_pipe.sv
// rtl/execute_pipe.sv - execute stage: operand select, ALU, condition codes, condition eval and E/M register
module execute_pipe
  import execute_pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int STAT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [DATA_W-1:0] E_valA,
  input  logic [DATA_W-1:0] E_valB,
  input  logic [DATA_W-1:0] E_valC,
  input  logic [3:0]        E_dstE,
  input  logic [3:0]        E_dstM,
  input  logic [STAT_W-1:0] E_stat,
  input  logic [STAT_W-1:0] m_stat,
  input  logic [STAT_W-1:0] W_stat,
  input  logic              M_stall,
  input  logic              M_bubble,
  output logic [DATA_W-1:0] e_valE,
  output logic [3:0]        e_dstE,
  output logic              e_cnd,
  output logic [3:0]        M_icode,
  output logic [3:0]        M_ifun,
  output logic [STAT_W-1:0] M_stat,
  output logic [DATA_W-1:0] M_valE,
  output logic [DATA_W-1:0] M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM,
  output logic              M_cnd,
  output logic [2:0]        cc
);

  localparam logic [DATA_W-1:0] WORD_BYTES = DATA_W'(DATA_W / 8);
  localparam logic [STAT_W-1:0] STAT_AOK   = STAT_W'(AOK);

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_fn;
  logic              new_zf;
  logic              new_sf;
  logic              new_of;
  logic              cnd_raw;
  logic              cc_zf;
  logic              cc_sf;
  logic              cc_of;

  logic [2:0]        cc_d,      cc_q;
  logic [3:0]        m_icode_d, m_icode_q;
  logic [3:0]        m_ifun_d,  m_ifun_q;
  logic [STAT_W-1:0] m_stat_d,  m_stat_q;
  logic [DATA_W-1:0] m_vale_d,  m_vale_q;
  logic [DATA_W-1:0] m_vala_d,  m_vala_q;
  logic [3:0]        m_dste_d,  m_dste_q;
  logic [3:0]        m_dstm_d,  m_dstm_q;
  logic              m_cnd_d,   m_cnd_q;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (E_icode)
      OPQ:    begin alu_a = E_valA;      alu_b = E_valB; end
      RRMOVQ: begin alu_a = E_valA;      alu_b = '0;     end
      IRMOVQ: begin alu_a = E_valC;      alu_b = '0;     end
      RMMOVQ,
      MRMOVQ: begin alu_a = E_valC;      alu_b = E_valB; end
      CALL,
      PUSHQ:  begin alu_a = -WORD_BYTES; alu_b = E_valB; end
      RET,
      POPQ:   begin alu_a = WORD_BYTES;  alu_b = E_valB; end
      default: ;
    endcase
    alu_fn = (E_icode == OPQ) ? E_ifun : ALU_ADD;
  end

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .alu_fn (alu_fn),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .result (e_valE),
    .zf     (new_zf),
    .sf     (new_sf),
    .of     (new_of)
  );

  // Conditions look at the flags already latched, not the ones this ALU op produces.
  always_comb begin
    {cc_zf, cc_sf, cc_of} = cc_q;
    case (E_ifun)
      4'd0:    cnd_raw = 1'b1;
      4'd1:    cnd_raw = (cc_sf ^ cc_of) | cc_zf;
      4'd2:    cnd_raw = cc_sf ^ cc_of;
      4'd3:    cnd_raw = cc_zf;
      4'd4:    cnd_raw = ~cc_zf;
      4'd5:    cnd_raw = ~(cc_sf ^ cc_of);
      4'd6:    cnd_raw = ~(cc_sf ^ cc_of) & ~cc_zf;
      default: cnd_raw = 1'b0;
    endcase
    e_cnd  = ((E_icode == RRMOVQ) || (E_icode == JXX)) ? cnd_raw : 1'b0;
    e_dstE = ((E_icode == RRMOVQ) && !e_cnd) ? RNONE : E_dstE;
  end

  always_comb begin
    cc_d = cc_q;
    if ((E_icode == OPQ) && (E_ifun <= ALU_XOR) && (m_stat == STAT_AOK) && (W_stat == STAT_AOK))
      cc_d = {new_zf, new_sf, new_of};
  end

  always_comb begin
    m_icode_d = m_icode_q;
    m_ifun_d  = m_ifun_q;
    m_stat_d  = m_stat_q;
    m_vale_d  = m_vale_q;
    m_vala_d  = m_vala_q;
    m_dste_d  = m_dste_q;
    m_dstm_d  = m_dstm_q;
    m_cnd_d   = m_cnd_q;
    if (!M_stall) begin
      if (M_bubble) begin
        m_icode_d = NOP;
        m_ifun_d  = 4'h0;
        m_stat_d  = STAT_AOK;
        m_vale_d  = '0;
        m_vala_d  = '0;
        m_dste_d  = RNONE;
        m_dstm_d  = RNONE;
        m_cnd_d   = 1'b0;
      end else begin
        m_icode_d = E_icode;
        m_ifun_d  = E_ifun;
        m_stat_d  = E_stat;
        m_vale_d  = e_valE;
        m_vala_d  = E_valA;
        m_dste_d  = e_dstE;
        m_dstm_d  = E_dstM;
        m_cnd_d   = e_cnd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q      <= 3'b100;
      m_icode_q <= NOP;
      m_ifun_q  <= 4'h0;
      m_stat_q  <= STAT_AOK;
      m_vale_q  <= '0;
      m_vala_q  <= '0;
      m_dste_q  <= RNONE;
      m_dstm_q  <= RNONE;
      m_cnd_q   <= 1'b0;
    end else begin
      cc_q      <= cc_d;
      m_icode_q <= m_icode_d;
      m_ifun_q  <= m_ifun_d;
      m_stat_q  <= m_stat_d;
      m_vale_q  <= m_vale_d;
      m_vala_q  <= m_vala_d;
      m_dste_q  <= m_dste_d;
      m_dstm_q  <= m_dstm_d;
      m_cnd_q   <= m_cnd_d;
    end
  end

  assign cc      = cc_q;
  assign M_icode = m_icode_q;
  assign M_ifun  = m_ifun_q;
  assign M_stat  = m_stat_q;
  assign M_valE  = m_vale_q;
  assign M_valA  = m_vala_q;
  assign M_dstE  = m_dste_q;
  assign M_dstM  = m_dstm_q;
  assign M_cnd   = m_cnd_q;

endmodule

// File: tb/tb_execute_pipe.sv
// tb/tb_execute_pipe.sv - directed scoreboard bench for execute_pipe (64-bit plus a 32-bit instance)
module tb_execute_pipe;
  import execute_pipe_pkg::*;

  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]    E_icode = NOP, E_ifun = 4'h0, E_dstE = RNONE, E_dstM = RNONE;
  logic [DW-1:0] E_valA = '0, E_valB = '0, E_valC = '0;
  logic [3:0]    E_stat = AOK, m_stat = AOK, W_stat = AOK;
  logic          M_stall = 1'b0, M_bubble = 1'b0;

  logic [DW-1:0] e_valE, M_valE, M_valA;
  logic [3:0]    e_dstE, M_icode, M_ifun, M_stat, M_dstE, M_dstM;
  logic          e_cnd, M_cnd;
  logic [2:0]    cc;

  logic [31:0]   e_valE32, M_valE32, M_valA32;
  logic [3:0]    e_dstE32, M_icode32, M_ifun32, M_stat32, M_dstE32, M_dstM32;
  logic          e_cnd32, M_cnd32;
  logic [2:0]    cc32;

  execute_pipe #(.DATA_W(DW), .STAT_W(4)) dut (
    .clk(clk), .rst(rst), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_stat(E_stat), .m_stat(m_stat), .W_stat(W_stat),
    .M_stall(M_stall), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd),
    .M_icode(M_icode), .M_ifun(M_ifun), .M_stat(M_stat), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_cnd(M_cnd), .cc(cc)
  );

  execute_pipe #(.DATA_W(32), .STAT_W(4)) dut32 (
    .clk(clk), .rst(rst), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA[31:0]), .E_valB(E_valB[31:0]), .E_valC(E_valC[31:0]),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_stat(E_stat), .m_stat(m_stat), .W_stat(W_stat),
    .M_stall(M_stall), .M_bubble(M_bubble),
    .e_valE(e_valE32), .e_dstE(e_dstE32), .e_cnd(e_cnd32),
    .M_icode(M_icode32), .M_ifun(M_ifun32), .M_stat(M_stat32), .M_valE(M_valE32), .M_valA(M_valA32),
    .M_dstE(M_dstE32), .M_dstM(M_dstM32), .M_cnd(M_cnd32), .cc(cc32)
  );

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  stat;
    logic [63:0] vale;
    logic [63:0] vala;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic        cnd;
  } m_t;

  localparam m_t M_RESET = '{4'h1, 4'h0, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0};

  m_t sb_q[$];
  m_t m_last = M_RESET;
  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_m(input string tag, input m_t e);
    chk({tag, ".M_icode"}, 64'(M_icode), 64'(e.icode));
    chk({tag, ".M_ifun"},  64'(M_ifun),  64'(e.ifun));
    chk({tag, ".M_stat"},  64'(M_stat),  64'(e.stat));
    chk({tag, ".M_valE"},  M_valE,       e.vale);
    chk({tag, ".M_valA"},  M_valA,       e.vala);
    chk({tag, ".M_dstE"},  64'(M_dstE),  64'(e.dste));
    chk({tag, ".M_dstM"},  64'(M_dstM),  64'(e.dstm));
    chk({tag, ".M_cnd"},   64'(M_cnd),   64'(e.cnd));
  endtask

  // Drive one E-stage instruction, check the combinational outputs, then check M and cc after the edge.
  task automatic op(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                    input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                    input logic [3:0] de, input logic [3:0] dm, input logic stall, input logic bubble,
                    input logic [3:0] ms, input logic [63:0] x_vale, input logic [3:0] x_dste,
                    input logic x_cnd, input logic [2:0] x_cc);
    m_t nxt;
    E_icode = ic; E_ifun = fn; E_valA = va; E_valB = vb; E_valC = vc;
    E_dstE = de; E_dstM = dm; M_stall = stall; M_bubble = bubble; m_stat = ms;
    #1;
    chk({tag, ".e_valE"}, e_valE, x_vale);
    chk({tag, ".e_dstE"}, 64'(e_dstE), 64'(x_dste));
    chk({tag, ".e_cnd"},  64'(e_cnd), 64'(x_cnd));
    if (stall)       nxt = m_last;
    else if (bubble) nxt = M_RESET;
    else             nxt = '{ic, fn, E_stat, x_vale, va, x_dste, dm, x_cnd};
    m_last = nxt;
    sb_q.push_back(nxt);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      $error("FAIL %s.scoreboard: observed empty queue expected an entry", tag);
    end else begin
      chk_m(tag, sb_q.pop_front());
    end
    chk({tag, ".cc"}, 64'(cc), 64'(x_cc));
  endtask

  initial begin
    #12;
    chk_m("reset", M_RESET);
    chk("reset.cc", 64'(cc), 64'(3'b100));
    @(posedge clk);
    #1 rst = 1'b0;

    op("sub_zero", OPQ,    4'h1, 64'd5, 64'd5, 64'h0, 4'h3, RNONE, 0, 0, AOK, 64'h0, 4'h3, 0, 3'b100);
    op("add_ovf",  OPQ,    4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h3, RNONE, 0, 0, AOK,
       64'h8000_0000_0000_0000, 4'h3, 0, 3'b011);
    op("add_madr", OPQ,    4'h0, 64'd2, 64'd3, 64'h0, 4'h3, RNONE, 0, 0, ADR, 64'd5, 4'h3, 0, 3'b011);
    op("sub_neg",  OPQ,    4'h1, 64'd2, 64'd1, 64'h0, 4'h3, RNONE, 0, 0, AOK, {64{1'b1}}, 4'h3, 0, 3'b010);
    op("cmovl_t",  RRMOVQ, 4'h2, 64'h1234, 64'h999, 64'h0, 4'h4, RNONE, 0, 0, AOK, 64'h1234, 4'h4, 1, 3'b010);
    op("xor",      OPQ,    4'h3, 64'd3, 64'd1, 64'h0, 4'h3, RNONE, 0, 0, AOK, 64'd2, 4'h3, 0, 3'b000);
    op("cmovl_f",  RRMOVQ, 4'h2, 64'h1234, 64'h0, 64'h0, 4'h4, RNONE, 0, 0, AOK, 64'h1234, RNONE, 0, 3'b000);
    op("jmp",      JXX,    4'h0, 64'h0, 64'h0, 64'h40, RNONE, RNONE, 0, 0, AOK, 64'h0, RNONE, 1, 3'b000);
    op("pushq",    PUSHQ,  4'h0, 64'h0, 64'h100, 64'h0, 4'h4, RNONE, 0, 0, AOK, 64'hF8, 4'h4, 0, 3'b000);
    chk("pushq32.e_valE", 64'(e_valE32), 64'hFC);
    op("popq",     POPQ,   4'h0, 64'h0, 64'h100, 64'h0, 4'h4, RNONE, 0, 0, AOK, 64'h108, 4'h4, 0, 3'b000);
    op("irmovq",   IRMOVQ, 4'h0, 64'h0, 64'h99, 64'h55, 4'h5, RNONE, 0, 0, AOK, 64'h55, 4'h5, 0, 3'b000);
    op("mrmovq",   MRMOVQ, 4'h0, 64'h77, 64'h100, 64'h8, RNONE, 4'h6, 0, 0, AOK, 64'h108, RNONE, 0, 3'b000);
    op("call",     CALL,   4'h0, 64'h0, 64'h100, 64'h0, 4'h4, RNONE, 0, 0, AOK, 64'hF8, 4'h4, 0, 3'b000);
    op("stall_bub", OPQ,   4'h1, 64'd5, 64'd5, 64'h0, 4'h3, RNONE, 1, 1, AOK, 64'h0, 4'h3, 0, 3'b100);
    op("bubble",   OPQ,    4'h0, 64'd1, 64'd1, 64'h0, 4'h3, RNONE, 0, 1, AOK, 64'd2, 4'h3, 0, 3'b000);
    op("rmmovq",   RMMOVQ, 4'h0, 64'hAB, 64'h10, 64'h20, RNONE, RNONE, 0, 0, AOK, 64'h30, RNONE, 0, 3'b000);

    #2 rst = 1'b1;
    #1;
    chk_m("mid_rst", M_RESET);
    chk("mid_rst.cc", 64'(cc), 64'(3'b100));
    #1 rst = 1'b0;
    sb_q.delete();
    m_last = M_RESET;

    op("post_rst", OPQ,    4'h0, 64'd2, 64'd3, 64'h0, 4'h3, RNONE, 0, 0, AOK, 64'd5, 4'h3, 0, 3'b000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
